// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, default timing.
// Used by both the receive and transmit halves of the console UART.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int CLK_HZ_DEF = 10_000_000;
  localparam int BAUD_DEF   = 115_200;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchronizer for an asynchronous input, reset to RST_VAL.
// Ports: clk, rst (sync, active high), d (async in), q (synchronized out).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a one-entry
// holding register (VALID/ACK). Ports: CLK, RST (sync, active high),
// RX (async line), DATA, VALID, ACK, FERR, OVR, BUSY; PERR and the ODD
// parameter exist only when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEF,
  parameter int BAUD         = BAUD_DEF,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit ODD          = 1'b0
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  input  logic              ACK,
  output logic              FERR,
  output logic              OVR,
`ifdef UART_RX_PARITY_EN
  output logic              PERR,
`endif
  output logic              BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic              rxs;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] sh;
  logic              brk;
  logic              bit_end;
  logic              commit;
`ifdef UART_RX_PARITY_EN
  logic              par;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX),
    .q   (rxs)
  );

  assign bit_end = (cnt == BIT_END);
  assign commit  = (state == S_STOP) && bit_end;
  assign BUSY    = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      brk   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          // After a framing error the line may still be in break;
          // wait for it to go high so the low level is not a new start.
          if (brk) begin
            if (rxs) brk <= 1'b0;
          end else if (!rxs) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            sh[idx] <= rxs;
            if (idx == 3'd7) state <= S_AFTER_DATA;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            par   <= rxs;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            brk   <= ~rxs;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A commit always wins over ACK; a simultaneous ACK just consumes
  // the old byte, so overrun is only flagged when nobody took it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA  <= '0;
      VALID <= 1'b0;
      FERR  <= 1'b0;
      OVR   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PERR  <= 1'b0;
`endif
    end else if (commit) begin
      DATA  <= sh;
      VALID <= 1'b1;
      FERR  <= ~rxs;
      OVR   <= VALID & ~ACK;
`ifdef UART_RX_PARITY_EN
      PERR  <= par ^ (^sh) ^ ODD;
`endif
    end else if (ACK && VALID) begin
      VALID <= 1'b0;
      FERR  <= 1'b0;
      OVR   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PERR  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames with a scoreboard
// queue, plus hand sequences for glitch, overrun, reset and parity.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 86;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 906;
`else
  localparam int LAT = 820;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX  = 1'b1;
  logic       ACK = 1'b0;
  logic [7:0] DATA;
  logic       VALID;
  logic       FERR;
  logic       OVR;
  logic       BUSY;
`ifdef UART_RX_PARITY_EN
  logic       PERR;
`endif

  uart_rx dut (
    .CLK   (CLK),
    .RST   (RST),
    .RX    (RX),
    .DATA  (DATA),
    .VALID (VALID),
    .ACK   (ACK),
    .FERR  (FERR),
    .OVR   (OVR),
`ifdef UART_RX_PARITY_EN
    .PERR  (PERR),
`endif
    .BUSY  (BUSY)
  );

  always #50 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  int   t_start = 0;
  int   rise_cyc = -1;
  int   busy_seen = 0;
  logic v_q = 1'b0;

  always @(negedge CLK) begin
    if (VALID && !v_q) rise_cyc = cyc;
    v_q = VALID;
    if (BUSY) busy_seen = busy_seen + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       ovr;
    logic       perr;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_ferr;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par);
    @(posedge CLK); #1;
    RX = 1'b0;
    t_start  = cyc;
    rise_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge CLK);
      #1 RX = d[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (CPB) @(posedge CLK);
    #1 RX = par;
`else
    if (par) RX = RX;
`endif
    repeat (CPB) @(posedge CLK);
    #1 RX = stop;
    repeat (CPB) @(posedge CLK);
    #1 RX = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!VALID && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (!VALID) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got VALID=0 want 1", nm);
    end
  endtask

  task automatic chk_lat(input string nm);
    int d;
    d = rise_cyc - t_start;
    checks++;
    if (rise_cyc < 0 || d < LAT - 1 || d > LAT + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d+-1", nm, d, LAT);
    end
  endtask

  task automatic check_pop(input string nm);
    exp_t e;
    @(negedge CLK);
    if (sbq.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s_sb_empty: got 0 entries want 1", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_valid"}, 32'(VALID), 32'd1);
      chk({nm, "_data"},  32'(DATA),  32'(e.data));
      chk({nm, "_ferr"},  32'(FERR),  32'(e.ferr));
      chk({nm, "_ovr"},   32'(OVR),   32'(e.ovr));
`ifdef UART_RX_PARITY_EN
      chk({nm, "_perr"},  32'(PERR),  32'(e.perr));
`endif
    end
  endtask

  task automatic do_ack(input string nm);
    @(posedge CLK); #1 ACK = 1'b1;
    @(posedge CLK); #1 ACK = 1'b0;
    @(negedge CLK);
    chk({nm, "_ack_valid"}, 32'(VALID), 32'd0);
    chk({nm, "_ack_ferr"},  32'(FERR),  32'd0);
    chk({nm, "_ack_ovr"},   32'(OVR),   32'd0);
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic f,
                              input logic o, input logic p);
    exp_t e;
    e.data = d;
    e.ferr = f;
    e.ovr  = o;
    e.perr = p;
    return e;
  endfunction

  initial begin
    #8ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts;
    int lat0;

    vt[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    vt[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
    vt[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vt[4] = '{8'hC9, 1'b1, 8'hC9, 1'b0};

    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_data",  32'(DATA),  32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_ferr",  32'(FERR),  32'd0);
    chk("rst_ovr",   32'(OVR),   32'd0);
    chk("rst_busy",  32'(BUSY),  32'd0);
    repeat (10) @(posedge CLK);

    for (int i = 0; i < 5; i++) begin
      sbq.push_back(mk(vt[i].exp_d, vt[i].exp_ferr, 1'b0, 1'b0));
      send_frame(vt[i].d, vt[i].stop, ^vt[i].d);
      wait_valid("vec");
      chk_lat("vec");
      check_pop("vec");
      do_ack("vec");
      repeat (20) @(posedge CLK);
    end

    busy_seen = 0;
    rise_cyc  = -1;
    @(posedge CLK); #1 RX = 1'b0;
    repeat (20) @(posedge CLK);
    #1 RX = 1'b1;
    repeat (45) @(posedge CLK);
    @(negedge CLK);
    chk("glitch_busy_end",  32'(BUSY), 32'd0);
    chk("glitch_busy_seen", 32'(busy_seen > 0), 32'd1);
    repeat (900) @(posedge CLK);
    chk("glitch_no_valid", 32'(rise_cyc == -1), 32'd1);

    send_frame(8'h12, 1'b1, ^8'h12);
    wait_valid("ovr1");
    lat0 = rise_cyc - t_start;
    repeat (20) @(posedge CLK);
    sbq.push_back(mk(8'h34, 1'b0, 1'b1, 1'b0));
    send_frame(8'h34, 1'b1, ^8'h34);
    check_pop("ovr2");
    do_ack("ovr2");
    repeat (20) @(posedge CLK);

    send_frame(8'h12, 1'b1, ^8'h12);
    wait_valid("ovra1");
    lat0 = rise_cyc - t_start;
    repeat (20) @(posedge CLK);
    sbq.push_back(mk(8'h34, 1'b0, 1'b0, 1'b0));
    fork
      send_frame(8'h34, 1'b1, ^8'h34);
      begin
        @(posedge CLK); #2;
        ts = t_start;
        while (cyc < ts + lat0 - 1) begin
          @(posedge CLK); #1;
        end
        ACK = 1'b1;
        @(posedge CLK); #1 ACK = 1'b0;
      end
    join
    check_pop("ovr_ack");
    do_ack("ovr_ack");
    repeat (20) @(posedge CLK);

    fork
      send_frame(8'hFF, 1'b1, ^8'hFF);
      begin
        @(posedge CLK); #2;
        ts = t_start;
        while (cyc < ts + 2 + 43 + 4 * CPB) begin
          @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_busy",  32'(BUSY),  32'd0);
        chk("rst_mid_valid", 32'(VALID), 32'd0);
      end
    join
    repeat (200) @(posedge CLK);
    chk("rst_mid_no_valid", 32'(rise_cyc == -1), 32'd1);
    sbq.push_back(mk(8'h0F, 1'b0, 1'b0, 1'b0));
    send_frame(8'h0F, 1'b1, ^8'h0F);
    wait_valid("post_rst");
    chk_lat("post_rst");
    check_pop("post_rst");
    do_ack("post_rst");

`ifdef UART_RX_PARITY_EN
    repeat (20) @(posedge CLK);
    sbq.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
    send_frame(8'h07, 1'b1, 1'b1);
    wait_valid("par_ok");
    chk_lat("par_ok");
    check_pop("par_ok");
    do_ack("par_ok");
    repeat (20) @(posedge CLK);
    sbq.push_back(mk(8'h07, 1'b0, 1'b0, 1'b1));
    send_frame(8'h07, 1'b1, 1'b0);
    wait_valid("par_bad");
    chk_lat("par_bad");
    check_pop("par_bad");
    do_ack("par_bad");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
